// File: rtl/gray_conv_arbiter.sv
// Purpose: round-robin arbiter sharing one binary_to_gray converter among NREQ requesters.
// Latency: a value accepted on edge N is presented on out_gray/out_id with out_valid=1 after edge N.
// Backpressure: one-entry output stage; req_ready only while empty or draining (out_ready=1), else all 0.
// Build option: define GRAY_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no rr pointer).

module binary_to_gray #(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] bin_i,
   output logic [BITS-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

module gray_conv_arbiter #(
   parameter  int BITS = 8,
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*BITS-1:0] req_binary,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BITS-1:0]      out_gray,
   output logic [IDW-1:0]       out_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [BITS-1:0]   gray_q, gray_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [IDW-1:0]    rr_ptr;

   logic              any_vld;
   logic [IDW-1:0]    win_id;
   logic              can_accept;
   logic              xfer;
   logic [BITS-1:0]   sel_bin;
   logic [BITS-1:0]   sel_gray;

   // Circular scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      logic [IDW:0] idx;
      any_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!any_vld && req_valid[idx[IDW-1:0]]) begin
            any_vld = 1'b1;
            win_id  = idx[IDW-1:0];
         end
      end
   end

   // A slot is free when empty, or when the held result drains this cycle.
   assign can_accept = (state_q == EMPTY) || out_ready;
   assign xfer       = any_vld && can_accept;
   // rst_n gating keeps every ready low while reset is asserted.
   assign req_ready  = (xfer && rst_n) ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;

   assign sel_bin = req_binary[win_id*BITS +: BITS];

   binary_to_gray #(.BITS(BITS)) u_b2g (
      .bin_i  (sel_bin),
      .gray_o (sel_gray)
   );

`ifdef GRAY_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   assign rr_ptr = rr_ptr_q;

   // Pointer moves just past the winner on every transfer, wrapping at NREQ.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Output-stage next state: load on transfer, drain to EMPTY otherwise; data holds when not loading.
   always_comb begin
      state_d = state_q;
      gray_d  = gray_q;
      id_d    = id_q;
      if (xfer) begin
         gray_d = sel_gray;
         id_d   = win_id;
      end
      case (state_q)
         EMPTY: begin
            if (xfer) state_d = FULL;
         end
         FULL: begin
            if (xfer)           state_d = FULL;
            else if (out_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output-stage registers; reset discards any pending result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         gray_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         gray_q  <= gray_d;
         id_q    <= id_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_gray  = gray_q;
   assign out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

   localparam int BITS = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*BITS-1:0] req_binary;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [BITS-1:0]      out_gray;
   logic [IDW-1:0]       out_id;

   int errors = 0;
   int checks = 0;

   gray_conv_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_binary (req_binary),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_gray   (out_gray),
      .out_id     (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0]      vld;
      logic [NREQ*BITS-1:0] bin;
      logic                 ordy;
      logic [NREQ-1:0]      exp_rdy;
      logic                 exp_ov;
      logic [BITS-1:0]      exp_gray;
      logic [IDW-1:0]       exp_id;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs[NVEC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle: drive at negedge, check ready before the edge, check outputs #1 after it.
   task automatic run_cycle(input string nm, input logic [NREQ-1:0] vld, input logic [NREQ*BITS-1:0] bin,
                            input logic ordy, input logic [NREQ-1:0] e_rdy, input logic e_ov,
                            input logic [BITS-1:0] e_gray, input logic [IDW-1:0] e_id);
      req_valid  = vld;
      req_binary = bin;
      out_ready  = ordy;
      #1;
      chk({nm, " req_ready"}, 32'(req_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk({nm, " out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({nm, " out_gray"},  32'(out_gray),  32'(e_gray));
      chk({nm, " out_id"},    32'(out_id),    32'(e_id));
      @(negedge clk);
   endtask

   initial begin
      logic [BITS-1:0] prev_gray;
      logic [BITS-1:0] exp_g;
      logic [BITS-1:0] b;

      //        vld      bin           ordy  rdy      ov    gray   id
      vecs[0]  = '{4'b1111, 32'h3C80FF05, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0};
      vecs[1]  = '{4'b1111, 32'h3C80FF05, 1'b1, 4'b0010, 1'b1, 8'h80, 2'd1};
      vecs[2]  = '{4'b1111, 32'h3C80FF05, 1'b1, 4'b0100, 1'b1, 8'hC0, 2'd2};
      vecs[3]  = '{4'b1111, 32'h3C80FF05, 1'b1, 4'b1000, 1'b1, 8'h22, 2'd3};
      vecs[4]  = '{4'b1111, 32'h3C80FF05, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0};
      vecs[5]  = '{4'b0000, 32'h3C80FF05, 1'b1, 4'b0000, 1'b0, 8'h07, 2'd0};
      vecs[6]  = '{4'b0100, 32'h3C0AFF05, 1'b1, 4'b0100, 1'b1, 8'h0F, 2'd2};
      vecs[7]  = '{4'b1000, 32'h3C80FF05, 1'b1, 4'b1000, 1'b1, 8'h22, 2'd3};
      vecs[8]  = '{4'b1001, 32'h3C80FF05, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0};
      vecs[9]  = '{4'b0010, 32'h3C80FF05, 1'b0, 4'b0000, 1'b1, 8'h07, 2'd0};
      vecs[10] = '{4'b0010, 32'h3C80FF05, 1'b0, 4'b0000, 1'b1, 8'h07, 2'd0};
      vecs[11] = '{4'b0010, 32'h3C80FF05, 1'b0, 4'b0000, 1'b1, 8'h07, 2'd0};
      vecs[12] = '{4'b0010, 32'h3C80FF05, 1'b1, 4'b0010, 1'b1, 8'h80, 2'd1};
      vecs[13] = '{4'b0000, 32'h3C80FF05, 1'b0, 4'b0000, 1'b1, 8'h80, 2'd1};
      vecs[14] = '{4'b0000, 32'h3C80FF05, 1'b1, 4'b0000, 1'b0, 8'h80, 2'd1};
      vecs[15] = '{4'b0010, 32'h3C800A05, 1'b0, 4'b0010, 1'b1, 8'h0F, 2'd1};
      vecs[16] = '{4'b0110, 32'h3C80FF05, 1'b1, 4'b0100, 1'b1, 8'hC0, 2'd2};

      // Power-on reset with requests already pending.
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_binary = 32'h3C80FF05;
      out_ready  = 1'b1;
      #3;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_gray",  32'(out_gray),  32'd0);
      chk("reset out_id",    32'(out_id),    32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifndef GRAY_ARB_FIXED_PRIO_EN
      // Round-robin, idle, wrap and backpressure table.
      for (int i = 0; i < NVEC; i++) begin
         run_cycle($sformatf("v%0d", i), vecs[i].vld, vecs[i].bin, vecs[i].ordy,
                   vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_gray, vecs[i].exp_id);
      end
      // Reqs 1 and 3 contend with pointer at 3: grants alternate 3,1,3,1.
      run_cycle("alt0", 4'b1010, 32'h3C80FF05, 1'b1, 4'b1000, 1'b1, 8'h22, 2'd3);
      run_cycle("alt1", 4'b1010, 32'h3C80FF05, 1'b1, 4'b0010, 1'b1, 8'h80, 2'd1);
      run_cycle("alt2", 4'b1010, 32'h3C80FF05, 1'b1, 4'b1000, 1'b1, 8'h22, 2'd3);
      run_cycle("alt3", 4'b1010, 32'h3C80FF05, 1'b1, 4'b0010, 1'b1, 8'h80, 2'd1);
`else
      // Fixed priority: req 1 beats req 3 every cycle.
      for (int i = 0; i < 4; i++) begin
         run_cycle($sformatf("fix%0d", i), 4'b1010, 32'h3C80FF05, 1'b1, 4'b0010, 1'b1, 8'h80, 2'd1);
      end
`endif

      // Exhaustive sweep through requester 1 at full throughput.
      prev_gray = '0;
      for (int i = 0; i < 256; i++) begin
         b          = 8'(i);
         exp_g      = b ^ (b >> 1);
         req_valid  = 4'b0010;
         req_binary = {8'h3C, 8'h80, b, 8'h05};
         out_ready  = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("sweep%0d out_gray", i), 32'(out_gray), 32'(exp_g));
         chk($sformatf("sweep%0d out_valid", i), 32'(out_valid), 32'd1);
         if (i > 0) begin
            chk($sformatf("sweep%0d one-bit step", i), 32'($countones(out_gray ^ prev_gray)), 32'd1);
         end
         prev_gray = out_gray;
         @(negedge clk);
      end

      // Reset mid-stream while FULL: result discarded without a clock edge.
      req_valid  = 4'b1111;
      req_binary = 32'h3C80FF05;
      out_ready  = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_gray",  32'(out_gray),  32'd0);
      chk("midrst out_id",    32'(out_id),    32'd0);
      chk("midrst req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // Pointer restarts at 0 after reset.
      run_cycle("postrst", 4'b1111, 32'h3C80FF05, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
